mcu_clock_sequencer: RTL

MCU_CLOCK_SEQUENCER -- requirements
Module: mcu_clock_sequencer

---
 rtl/mcu_clock_sequencer_pkg.sv | 22 ++
 rtl/mcu_clock_sequencer_key_debounce.sv | 51 +++++
 rtl/mcu_clock_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mcu_clock_sequencer_pkg.sv
// Shared types for the MCU clock sequencer.
// Holds the 2-bit mode encoding and the mode-advance order.
package mcu_clock_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_SLOW  = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  // Cyclic order: RUN -> SLOW -> STEP -> BURST -> RUN
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:   next_mode = MODE_SLOW;
      MODE_SLOW:  next_mode = MODE_STEP;
      MODE_STEP:  next_mode = MODE_BURST;
      default:    next_mode = MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/mcu_clock_sequencer_key_debounce.sv
// Key conditioning for one raw active-low push key.
// Two-flop synchronizer, then a debouncer that accepts a new level only after
// DEBOUNCE_CYCLES consecutive synchronized samples that differ from the
// accepted level, then a one-cycle press pulse on each accepted 1->0 change.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   key_n        : raw key, active-low, asynchronous to clk
//   press        : registered one-cycle pulse on an accepted press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt tracks how many consecutive samples have disagreed with level; a
  // sample that agrees again restarts it from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mcu_clock_sequencer.sv
// MCU clock sequencer: generates a clock enable for an MCU core in one of
// four modes selected by a mode key (RUN, SLOW, STEP, BURST) and counts the
// enabled cycles. Pressing both keys together clears the cycle count.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   mode_key_n   : raw mode key, active-low
//   step_key_n   : raw step key, active-low
//   mcu_clk_en   : registered MCU clock enable
//   mode         : current mode (00 RUN, 01 SLOW, 10 STEP, 11 BURST)
//   busy         : high while a BURST sequence runs
//   step_count   : number of cycles with mcu_clk_en=1 (wrapping)
module mcu_clock_sequencer
  import mcu_clock_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SLOW_DIV        = 8388608,
  parameter int unsigned BURST_LEN       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_key_n,
  input  logic        step_key_n,
  output logic        mcu_clk_en,
  output logic [1:0]  mode,
  output logic        busy,
  output logic [31:0] step_count
);

  localparam int unsigned DIV_W   = $clog2(SLOW_DIV + 1);
  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SLOW_DIV - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN);

  logic               mode_press;
  logic               step_press;
  mode_t              mode_q;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst;

  logic mode_evt;
  logic clear_evt;
  logic slow_wrap;
  logic burst_start;
  logic burst_done;
  logic en_next;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (mode_key_n),
    .press   (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (step_key_n),
    .press   (step_press)
  );

  // burst counts enable cycles already issued, so it reaches BURST_LEN on
  // the last enabled cycle of the sequence.
  always_comb begin
    mode_evt    = mode_press & ~step_press;
    clear_evt   = mode_press & step_press;
    slow_wrap   = (div == DIV_LAST);
    burst_start = (mode_q == MODE_BURST) & step_press & ~mode_press & ~busy;
    burst_done  = busy & (burst == BURST_LAST);
    en_next     = 1'b0;
    // Any mode-key event (alone or with step) forces the enable low.
    if (!mode_press) begin
      case (mode_q)
        MODE_RUN:   en_next = 1'b1;
        MODE_SLOW:  en_next = slow_wrap;
        MODE_STEP:  en_next = step_press;
        MODE_BURST: en_next = burst_start | (busy & ~burst_done);
        default:    en_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_RUN;
    end else if (mode_evt) begin
      mode_q <= next_mode(mode_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (mode_evt) begin
      div <= '0;
    end else if (mode_q == MODE_SLOW) begin
      div <= slow_wrap ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      burst <= '0;
    end else if (mode_evt) begin
      busy  <= 1'b0;
      burst <= '0;
    end else if (burst_start) begin
      busy  <= 1'b1;
      burst <= BURST_W'(1);
    end else if (busy) begin
      if (burst_done) begin
        busy  <= 1'b0;
        burst <= '0;
      end else begin
        burst <= burst + BURST_W'(1);
      end
    end
  end

  // step_count is advanced with the enable it accompanies, so it already
  // includes the cycle currently being enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcu_clk_en <= 1'b0;
      step_count <= '0;
    end else begin
      mcu_clk_en <= en_next;
      if (clear_evt) begin
        step_count <= '0;
      end else begin
        step_count <= step_count + {31'd0, en_next};
      end
    end
  end

  assign mode = mode_q;

endmodule
